// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmit line between two byte requesters.
// The granted byte is sent as an 8N1/8N2 frame, advancing one bit per txclk_en_i tick.
module uart_tx_arbiter #(
    parameter int unsigned STOP_BITS = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       txclk_en_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    output logic       req1_ready_o,
    output logic       tx_o,
    output logic       busy_o,
    output logic [1:0] grant_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StStart,
        StData,
        StStop
    } state_e;

    localparam logic StopLast = 1'(STOP_BITS - 1);

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       last_grant_q, last_grant_d;
    logic [1:0] grant_q, grant_d;
    logic       busy_q, busy_d;
    logic       tx_q, tx_d;
    logic       sel;
    logic       accept;

    // On a tie the requester that did not own the previous frame wins.
    always_comb begin
        if (req0_valid_i && req1_valid_i) begin
            sel = ~last_grant_q;
        end else begin
            sel = req1_valid_i;
        end
    end

    // Readies are held low while reset is asserted even though the state reads idle.
    assign req0_ready_o = !rst_i && (state_q == StIdle) && !sel && req0_valid_i;
    assign req1_ready_o = !rst_i && (state_q == StIdle) && sel && req1_valid_i;
    assign accept       = req0_ready_o || req1_ready_o;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        busy_d       = busy_q;
        tx_d         = tx_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    shift_d      = sel ? req1_data_i : req0_data_i;
                    last_grant_d = sel;
                    grant_d      = sel ? 2'b10 : 2'b01;
                    busy_d       = 1'b1;
                    state_d      = StWait;
                end
            end
            StWait: begin
                if (txclk_en_i) begin
                    tx_d    = 1'b0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (txclk_en_i) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = 3'd0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (txclk_en_i) begin
                    if (bit_cnt_q != 3'd7) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = StStop;
                    end
                end
            end
            StStop: begin
                if (txclk_en_i) begin
                    if (stop_cnt_q == StopLast) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                        grant_d = 2'b00;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            stop_cnt_q   <= 1'b0;
            last_grant_q <= 1'b1;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            busy_q       <= busy_d;
            tx_q         <= tx_d;
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: one instance with one stop bit and one with two, each driven by
// its own requesters; a frame-level reference model predicts readies and the serial line.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tick = 1'b0;

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic       tx_a    [2];
    logic       busy_a  [2];
    logic [1:0] grant_a [2];
    logic       r0_a    [2];
    logic       r1_a    [2];
    logic       v0_a    [2];
    logic       v1_a    [2];

    // Scoreboard: index 2*instance + requester, bytes pushed when offered.
    logic [7:0] sb [4][$];

    logic [7:0] dir_data [2][8];
    int         dir_len  [2] = '{0, 0};
    int         dir_gen  [2] = '{0, 0};
    int         phase = 0;
    int         frames [2] = '{0, 0};

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic       v [2];
        logic [7:0] d [2];
        logic       r [2];
        logic       tx;
        logic       busy;
        logic [1:0] grant;

        uart_tx_arbiter #(
            .STOP_BITS(g + 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .txclk_en_i  (tick),
            .req0_valid_i(v[0]),
            .req0_data_i (d[0]),
            .req0_ready_o(r[0]),
            .req1_valid_i(v[1]),
            .req1_data_i (d[1]),
            .req1_ready_o(r[1]),
            .tx_o        (tx),
            .busy_o      (busy),
            .grant_o     (grant)
        );

        assign tx_a[g]    = tx;
        assign busy_a[g]  = busy;
        assign grant_a[g] = grant;
        assign r0_a[g]    = r[0];
        assign r1_a[g]    = r[1];
        assign v0_a[g]    = v[0];
        assign v1_a[g]    = v[1];

        // Requesters: hold valid/data until accepted, except tentative offers that may give up.
        initial begin : drv
            bit pend [2];
            bit tent [2];
            bit dropped;
            int hold [2];
            int idx  [2];
            int seen [2];
            for (int n = 0; n < 2; n++) begin
                v[n]    = 1'b0;
                d[n]    = 8'h00;
                pend[n] = 1'b0;
                tent[n] = 1'b0;
                hold[n] = 0;
                idx[n]  = 0;
                seen[n] = 0;
            end
            forever begin
                @(negedge clk);
                for (int n = 0; n < 2; n++) begin
                    dropped = 1'b0;
                    if (seen[n] != dir_gen[n]) begin
                        seen[n] = dir_gen[n];
                        idx[n]  = 0;
                    end
                    if (pend[n]) begin
                        pend[n] = 1'b0;
                        v[n]    = 1'b0;
                    end else if (v[n] && tent[n]) begin
                        hold[n]--;
                        if (hold[n] <= 0) begin
                            v[n]    = 1'b0;
                            dropped = 1'b1;
                            void'(sb[2*g+n].pop_back());
                        end
                    end
                    if (!v[n] && !dropped) begin
                        if (phase == 1 && idx[n] < dir_len[n]) begin
                            d[n]    = dir_data[n][idx[n]];
                            idx[n]++;
                            tent[n] = 1'b0;
                            v[n]    = 1'b1;
                            sb[2*g+n].push_back(d[n]);
                        end else if (phase == 2 && $urandom_range(0, 5) == 0) begin
                            d[n]    = 8'($urandom);
                            tent[n] = ($urandom_range(0, 3) == 0);
                            hold[n] = int'($urandom_range(1, 20));
                            v[n]    = 1'b1;
                            sb[2*g+n].push_back(d[n]);
                        end
                    end
                end
                #1;
                for (int n = 0; n < 2; n++) begin
                    if (v[n] && r[n]) pend[n] = 1'b1;
                end
            end
        end
    end

    initial begin : tick_gen
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            tick = (cyc % 4 == 3);
            cyc++;
        end
    end

    // Reference model: tracks only "busy" and "ticks since acceptance" per instance; the line
    // level follows from the frame layout (start, 8 data bits LSB first, stop bits).
    initial begin : model
        bit         m_busy [2];
        int         m_tick [2];
        logic [7:0] m_data [2];
        logic       m_own  [2];
        logic       m_last [2];
        logic       sel;
        logic       acc;
        logic       exp_tx;
        logic [1:0] exp_gnt;
        int         q;
        string      tag;
        for (int g = 0; g < 2; g++) begin
            m_busy[g] = 1'b0;
            m_tick[g] = 0;
            m_data[g] = 8'h00;
            m_own[g]  = 1'b0;
            m_last[g] = 1'b1;
        end
        forever begin
            @(negedge clk);
            #1;
            for (int g = 0; g < 2; g++) begin
                tag = $sformatf("sb%0d", g + 1);
                if (rst) begin
                    check({tag, " reset tx"}, int'(tx_a[g]), 1);
                    check({tag, " reset busy"}, int'(busy_a[g]), 0);
                    check({tag, " reset grant"}, int'(grant_a[g]), 0);
                    check({tag, " reset ready0"}, int'(r0_a[g]), 0);
                    check({tag, " reset ready1"}, int'(r1_a[g]), 0);
                    m_busy[g] = 1'b0;
                    m_last[g] = 1'b1;
                end else begin
                    if (!m_busy[g] || m_tick[g] == 0 || m_tick[g] >= 10) exp_tx = 1'b1;
                    else if (m_tick[g] == 1) exp_tx = 1'b0;
                    else exp_tx = m_data[g][m_tick[g]-2];
                    exp_gnt = !m_busy[g] ? 2'b00 : (m_own[g] ? 2'b10 : 2'b01);
                    check({tag, " tx"}, int'(tx_a[g]), int'(exp_tx));
                    check({tag, " busy"}, int'(busy_a[g]), int'(m_busy[g]));
                    check({tag, " grant"}, int'(grant_a[g]), int'(exp_gnt));

                    if (v0_a[g] && v1_a[g]) sel = !m_last[g];
                    else sel = v1_a[g];
                    acc = !m_busy[g] && (v0_a[g] || v1_a[g]);
                    check({tag, " ready0"}, int'(r0_a[g]), int'(acc && !sel));
                    check({tag, " ready1"}, int'(r1_a[g]), int'(acc && sel));

                    if (acc) begin
                        q = 2 * g + int'(sel);
                        check({tag, " scoreboard has byte"}, int'(sb[q].size() > 0), 1);
                        if (sb[q].size() > 0) m_data[g] = sb[q].pop_front();
                        m_own[g]  = sel;
                        m_last[g] = sel;
                        m_busy[g] = 1'b1;
                        m_tick[g] = 0;
                        frames[g]++;
                    end else if (m_busy[g] && tick) begin
                        m_tick[g]++;
                        if (m_tick[g] == 10 + g + 1) m_busy[g] = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : main
        rst   = 1'b1;
        phase = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single byte on requester 0.
        dir_data[0][0] = 8'hA5;
        dir_len[0]     = 1;
        dir_len[1]     = 0;
        dir_gen[0]++;
        phase = 1;
        repeat (120) @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("sb%0d frames after single", g + 1),
                                          frames[g], 1);

        // Both valid straight out of reset, then requester 1 streams.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        dir_data[0][0] = 8'h11;
        dir_data[0][1] = 8'h33;
        dir_len[0]     = 2;
        dir_data[1][0] = 8'h22;
        dir_data[1][1] = 8'h44;
        dir_data[1][2] = 8'h01;
        dir_data[1][3] = 8'h02;
        dir_data[1][4] = 8'h03;
        dir_len[1]     = 5;
        dir_gen[0]++;
        dir_gen[1]++;
        repeat (450) @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("sb%0d frames after ties", g + 1),
                                          frames[g], 8);

        // Reset in the middle of a data bit while requester 0 waits.
        dir_data[1][0] = 8'h5A;
        dir_len[1]     = 1;
        dir_gen[1]++;
        repeat (24) @(negedge clk);
        dir_data[0][0] = 8'h3C;
        dir_len[0]     = 1;
        dir_gen[0]++;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("sb%0d busy before reset", g + 1), int'(busy_a[g]), 1);
            check($sformatf("sb%0d req0 waiting", g + 1), int'(v0_a[g]), 1);
        end
        rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("sb%0d async tx", g + 1), int'(tx_a[g]), 1);
            check($sformatf("sb%0d async busy", g + 1), int'(busy_a[g]), 0);
            check($sformatf("sb%0d async grant", g + 1), int'(grant_a[g]), 0);
            check($sformatf("sb%0d async ready0", g + 1), int'(r0_a[g]), 0);
            check($sformatf("sb%0d async ready1", g + 1), int'(r1_a[g]), 0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        for (int g = 0; g < 2; g++) check($sformatf("sb%0d frames after reset", g + 1),
                                          frames[g], 10);

        // Random traffic including abandoned offers, then drain.
        phase = 2;
        repeat (3000) @(negedge clk);
        phase = 0;
        repeat (200) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check($sformatf("sb%0d req0 drained", g + 1), sb[2*g].size(), 0);
            check($sformatf("sb%0d req1 drained", g + 1), sb[2*g+1].size(), 0);
            check($sformatf("sb%0d idle at end", g + 1), int'(busy_a[g]), 0);
            check($sformatf("sb%0d random frames seen", g + 1), int'(frames[g] > 30), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
